// File: rtl/inst_fetch.sv
// IF stage: owns the PC, drives the instruction ROM and fills the IF/ID register.
// Optional macro DELAY_SLOT_EN keeps the redirect-cycle word as an architectural delay slot.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ce,
    output logic [31:0] pc,
    input  logic [31:0] inst_i,
    input  logic        stall,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;

    state_t      state_q, state_d;
    logic        ce_q, ce_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic        id_valid_q, id_valid_d;
    logic        fault_q, fault_d;
    logic        misaligned;

    assign misaligned = branch_flag && (branch_target[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ce_q       <= 1'b0;
            pc_q       <= RESET_PC;
            id_pc_q    <= 32'h0000_0000;
            id_inst_q  <= NOP_WORD;
            id_valid_q <= 1'b0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ce_q       <= ce_d;
            pc_q       <= pc_d;
            id_pc_q    <= id_pc_d;
            id_inst_q  <= id_inst_d;
            id_valid_q <= id_valid_d;
            fault_q    <= fault_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ce_d       = ce_q;
        pc_d       = pc_q;
        id_pc_d    = id_pc_q;
        id_inst_d  = id_inst_q;
        id_valid_d = id_valid_q;
        fault_d    = fault_q;
        case (state_q)
            IDLE: begin
                state_d = RUN;
                ce_d    = 1'b1;
            end
            RUN: begin
                if (misaligned && !stall) begin
                    // pc keeps the last good address so the faulting redirect is traceable
                    state_d    = FAULT;
                    ce_d       = 1'b0;
                    id_inst_d  = NOP_WORD;
                    id_valid_d = 1'b0;
                    fault_d    = 1'b1;
                end else if (!stall) begin
                    id_pc_d = pc_q;
`ifdef DELAY_SLOT_EN
                    id_inst_d  = inst_i;
                    id_valid_d = 1'b1;
`else
                    id_inst_d  = branch_flag ? NOP_WORD : inst_i;
                    id_valid_d = !branch_flag;
`endif
                    pc_d = branch_flag ? branch_target : pc_q + 32'd4;
                end
            end
            FAULT: begin
                ce_d       = 1'b0;
                id_inst_d  = NOP_WORD;
                id_valid_d = 1'b0;
                fault_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
                ce_d    = 1'b0;
            end
        endcase
    end

    assign ce       = ce_q;
    assign pc       = pc_q;
    assign id_pc    = id_pc_q;
    assign id_inst  = id_inst_q;
    assign id_valid = id_valid_q;
    assign fault    = fault_q;

endmodule
